// File: rtl/time_entry_ctrl_pkg.sv
// Shared definitions for the countdown-timer time entry controller.
package time_entry_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_EDIT   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    localparam int unsigned MINS_STEP = 60;
    localparam int unsigned SECS_STEP = 1;

endpackage : time_entry_ctrl_pkg

// File: rtl/time_entry_ctrl_hold_repeat.sv
// Per-button edge detect plus press-and-hold auto-repeat; emits a one-cycle step request.
module time_entry_ctrl_hold_repeat #(
    parameter int unsigned HOLD_CYCLES   = 2500000,
    parameter int unsigned REPEAT_CYCLES = 500000
) (
    input  logic clk,
    input  logic rst,
    input  logic en_i,
    input  logic btn_i,
    output logic step_c
);

    localparam int unsigned MAX_CNT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int unsigned CW      = $clog2(MAX_CNT + 1);

    logic          btn_q;
    logic          rep_q;
    logic [CW-1:0] cnt_q;
    logic          rise_c;
    logic          hit_c;

    // cnt_q holds (cycles held - 1) during the current cycle, so a compare against N-1 fires on cycle N.
    always_comb begin
        rise_c = btn_i & ~btn_q;
        hit_c  = 1'b0;
        if (en_i && btn_i) begin
            if (rep_q) begin
                hit_c = (cnt_q == CW'(REPEAT_CYCLES - 1));
            end else begin
                hit_c = (cnt_q == CW'(HOLD_CYCLES - 1));
            end
        end
        step_c = en_i & (rise_c | hit_c);
    end

    // Edge history always tracks the button; hold counter only runs while held in edit.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            btn_q <= 1'b0;
            rep_q <= 1'b0;
            cnt_q <= '0;
        end else begin
            btn_q <= btn_i;
            if (!en_i || !btn_i) begin
                rep_q <= 1'b0;
                cnt_q <= '0;
            end else if (hit_c) begin
                rep_q <= 1'b1;
                cnt_q <= '0;
            end else begin
                cnt_q <= cnt_q + CW'(1);
            end
        end
    end

endmodule : time_entry_ctrl_hold_repeat

// File: rtl/time_entry_ctrl.sv
// Time entry controller: button-driven seconds editor feeding the countdown timer load handshake.
module time_entry_ctrl
    import time_entry_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W         = 12,
    parameter int unsigned MAX_SECS      = 3599,
    parameter int unsigned HOLD_CYCLES   = 2500000,
    parameter int unsigned REPEAT_CYCLES = 500000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_en,
    input  logic             mins,
    input  logic             secs,
    input  logic             load_ready,
    output logic             load_valid,
    output logic [CNT_W-1:0] load_value,
    output logic [CNT_W-1:0] edit_value,
    output logic             editing
);

    localparam int unsigned SUM_W = CNT_W + 1;

    state_e           state_q;
    logic [CNT_W-1:0] edit_q;
    logic [CNT_W-1:0] edit_d;
    logic [CNT_W-1:0] load_value_q;
    logic             load_valid_q;
    logic             editing_q;
    logic             clr_lock_q;
    logic             clr_lock_d;

    logic             active_c;
    logic             both_c;
    logic             clear_c;
    logic             step_ok_c;
    logic             mins_step_c;
    logic             secs_step_c;
    logic [SUM_W-1:0] step_amt;
    logic [SUM_W-1:0] sum;

    // Edits are only live while in EDIT with the switch still up; the exit cycle is frozen.
    assign active_c  = (state_q == ST_EDIT) & cfg_en;
    assign both_c    = mins & secs;
    assign clear_c   = active_c & both_c & ~clr_lock_q;
    assign step_ok_c = active_c & ~both_c & ~clr_lock_q;

    time_entry_ctrl_hold_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_mins (
        .clk    (clk),
        .rst    (rst),
        .en_i   (active_c),
        .btn_i  (mins),
        .step_c (mins_step_c)
    );

    time_entry_ctrl_hold_repeat #(
        .HOLD_CYCLES   (HOLD_CYCLES),
        .REPEAT_CYCLES (REPEAT_CYCLES)
    ) u_secs (
        .clk    (clk),
        .rst    (rst),
        .en_i   (active_c),
        .btn_i  (secs),
        .step_c (secs_step_c)
    );

    // Saturating add one bit wider than the value, plus the both-buttons clear and its lockout.
    always_comb begin
        step_amt   = '0;
        edit_d     = edit_q;
        clr_lock_d = clr_lock_q;
        if (step_ok_c) begin
            if (mins_step_c) step_amt = step_amt + SUM_W'(MINS_STEP);
            if (secs_step_c) step_amt = step_amt + SUM_W'(SECS_STEP);
        end
        sum = SUM_W'(edit_q) + step_amt;
        if (clear_c) begin
            edit_d = '0;
        end else if (step_amt != '0) begin
            edit_d = (sum > SUM_W'(MAX_SECS)) ? CNT_W'(MAX_SECS) : sum[CNT_W-1:0];
        end
        if (!active_c) begin
            clr_lock_d = 1'b0;
        end else if (both_c) begin
            clr_lock_d = 1'b1;
        end else if (!mins && !secs) begin
            clr_lock_d = 1'b0;
        end
    end

    // Mode FSM with registered handshake and status outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            edit_q       <= '0;
            load_value_q <= '0;
            load_valid_q <= 1'b0;
            editing_q    <= 1'b0;
            clr_lock_q   <= 1'b0;
        end else begin
            edit_q     <= edit_d;
            clr_lock_q <= clr_lock_d;
            case (state_q)
                ST_IDLE: begin
                    if (cfg_en) begin
                        state_q   <= ST_EDIT;
                        editing_q <= 1'b1;
                    end
                end
                ST_EDIT: begin
                    if (!cfg_en) begin
                        state_q      <= ST_COMMIT;
                        editing_q    <= 1'b0;
                        load_value_q <= edit_q;
                        load_valid_q <= 1'b1;
                    end
                end
                ST_COMMIT: begin
                    // valid is high throughout COMMIT, so ready alone completes the transfer.
                    if (load_ready) begin
                        state_q      <= ST_IDLE;
                        load_valid_q <= 1'b0;
                    end else if (cfg_en) begin
                        state_q      <= ST_EDIT;
                        load_valid_q <= 1'b0;
                        editing_q    <= 1'b1;
                    end
                end
                default: begin
                    state_q      <= ST_IDLE;
                    load_valid_q <= 1'b0;
                    editing_q    <= 1'b0;
                end
            endcase
        end
    end

    assign load_valid = load_valid_q;
    assign load_value = load_value_q;
    assign edit_value = edit_q;
    assign editing    = editing_q;

endmodule : time_entry_ctrl

// File: tb/tb_time_entry_ctrl.sv
// Bench for time_entry_ctrl: vector table, directed corner sequences, randomized run vs reference model.
module tb_time_entry_ctrl;

    localparam int HOLD   = 10;
    localparam int REPEAT = 4;
    localparam int MAXS   = 3599;

    logic        clk;
    logic        rst;
    logic        cfg_en;
    logic        mins;
    logic        secs;
    logic        load_ready;
    logic        load_valid;
    logic [11:0] load_value;
    logic [11:0] edit_value;
    logic        editing;

    int checks;
    int errors;

    // Reference model state
    bit m_in_edit, m_pending, m_lock, m_prev_m, m_prev_s, m_valid;
    int m_edit, m_load, m_hm, m_hs;

    time_entry_ctrl #(
        .CNT_W         (12),
        .MAX_SECS      (MAXS),
        .HOLD_CYCLES   (HOLD),
        .REPEAT_CYCLES (REPEAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .cfg_en     (cfg_en),
        .mins       (mins),
        .secs       (secs),
        .load_ready (load_ready),
        .load_valid (load_valid),
        .load_value (load_value),
        .edit_value (edit_value),
        .editing    (editing)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic bit fires(input int c);
        return (c == HOLD) || (c > HOLD && ((c - HOLD) % REPEAT) == 0);
    endfunction

    function automatic void model_reset();
        m_in_edit = 0; m_pending = 0; m_lock = 0; m_prev_m = 0; m_prev_s = 0;
        m_valid = 0; m_edit = 0; m_load = 0; m_hm = 0; m_hs = 0;
    endfunction

    // One clock of the behavioural model using the inputs present at the edge.
    function automatic void model_step();
        bit active, both, st_m, st_s;
        int add;
        int old_edit;
        old_edit = m_edit;
        active = m_in_edit && cfg_en;
        both   = mins && secs;
        m_hm   = (active && mins) ? m_hm + 1 : 0;
        m_hs   = (active && secs) ? m_hs + 1 : 0;
        st_m   = active && mins && ((mins && !m_prev_m) || fires(m_hm));
        st_s   = active && secs && ((secs && !m_prev_s) || fires(m_hs));
        if (active && both && !m_lock) begin
            m_edit = 0;
        end else if (active && !both && !m_lock) begin
            add = (st_m ? 60 : 0) + (st_s ? 1 : 0);
            if (add > 0) m_edit = (m_edit + add > MAXS) ? MAXS : m_edit + add;
        end
        if (!active) m_lock = 0;
        else if (both) m_lock = 1;
        else if (!mins && !secs) m_lock = 0;
        if (m_in_edit) begin
            if (!cfg_en) begin
                m_in_edit = 0; m_pending = 1; m_load = old_edit;
            end
        end else if (m_pending) begin
            if (load_ready) m_pending = 0;
            else if (cfg_en) begin
                m_pending = 0; m_in_edit = 1;
            end
        end else if (cfg_en) begin
            m_in_edit = 1;
        end
        m_valid  = m_pending;
        m_prev_m = mins;
        m_prev_s = secs;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rst) model_reset();
        else model_step();
        #1;
        check("model_valid", int'(load_valid), int'(m_valid));
        check("model_load", int'(load_value), m_load);
        check("model_edit", int'(edit_value), m_edit);
        check("model_editing", int'(editing), int'(m_in_edit));
    endtask

    task automatic drive(input bit c, input bit m, input bit s, input bit r);
        cfg_en = c; mins = m; secs = s; load_ready = r;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);
        cyc();
        cyc();
        rst = 1'b0;
    endtask

    // Press a button for len cycles then release for one cycle, staying in edit mode.
    task automatic press(input bit is_mins, input int len);
        for (int i = 0; i < len; i++) begin
            drive(1, is_mins, !is_mins, 0);
            cyc();
        end
        drive(1, 0, 0, 0);
        cyc();
    endtask

    typedef struct {
        bit cfg; bit m; bit s; bit r;
        bit e_valid; int e_load; int e_edit; bit e_editing;
    } vec_t;

    vec_t vt[$];

    initial begin
        checks = 0;
        errors = 0;
        model_reset();
        rst = 1'b1;
        drive(0, 0, 0, 0);

        // Reset state
        cyc();
        check("rst_valid", int'(load_valid), 0);
        check("rst_load", int'(load_value), 0);
        check("rst_edit", int'(edit_value), 0);
        check("rst_editing", int'(editing), 0);
        rst = 1'b0;

        // Two mins presses, five secs pulses, commit with ready, re-edit, abort and recommit
        vt.push_back('{1,0,0,0, 0,0,0,1});
        vt.push_back('{1,1,0,0, 0,0,60,1});
        vt.push_back('{1,1,0,0, 0,0,60,1});
        vt.push_back('{1,1,0,0, 0,0,60,1});
        vt.push_back('{1,0,0,0, 0,0,60,1});
        vt.push_back('{1,1,0,0, 0,0,120,1});
        vt.push_back('{1,1,0,0, 0,0,120,1});
        vt.push_back('{1,1,0,0, 0,0,120,1});
        vt.push_back('{1,0,0,0, 0,0,120,1});
        for (int k = 1; k <= 5; k++) begin
            vt.push_back('{1,0,1,0, 0,0,120+k,1});
            vt.push_back('{1,0,0,0, 0,0,120+k,1});
        end
        vt.push_back('{0,0,0,1, 1,125,125,0});
        vt.push_back('{0,0,0,1, 0,125,125,0});
        vt.push_back('{0,0,0,0, 0,125,125,0});
        vt.push_back('{1,0,0,0, 0,125,125,1});
        vt.push_back('{1,0,1,0, 0,125,126,1});
        vt.push_back('{0,0,0,0, 1,126,126,0});
        vt.push_back('{0,0,0,0, 1,126,126,0});
        vt.push_back('{1,0,0,0, 0,126,126,1});
        vt.push_back('{0,0,0,0, 1,126,126,0});
        vt.push_back('{0,0,0,1, 0,126,126,0});
        vt.push_back('{0,0,0,1, 0,126,126,0});

        foreach (vt[i]) begin
            drive(vt[i].cfg, vt[i].m, vt[i].s, vt[i].r);
            cyc();
            check($sformatf("tbl%0d_valid", i), int'(load_valid), int'(vt[i].e_valid));
            check($sformatf("tbl%0d_load", i), int'(load_value), vt[i].e_load);
            check($sformatf("tbl%0d_edit", i), int'(edit_value), vt[i].e_edit);
            check($sformatf("tbl%0d_editing", i), int'(editing), int'(vt[i].e_editing));
        end

        // Saturation at 59:59
        do_reset();
        drive(1, 0, 0, 0); cyc();
        for (int i = 0; i < 59; i++) press(1, 1);
        for (int i = 0; i < 30; i++) press(0, 1);
        check("sat_pre", int'(edit_value), 3570);
        press(1, 1);
        check("sat_mins", int'(edit_value), 3599);
        for (int i = 0; i < 3; i++) press(0, 1);
        check("sat_secs", int'(edit_value), 3599);

        // Hold secs for 22 cycles: steps at cycles 1, 10, 14, 18, 22
        do_reset();
        drive(1, 0, 0, 0); cyc();
        for (int c = 1; c <= 22; c++) begin
            drive(1, 0, 1, 0);
            cyc();
            check($sformatf("hold_c%0d", c), int'(edit_value),
                  1 + ((c >= HOLD) ? 1 + (c - HOLD) / REPEAT : 0));
        end
        drive(1, 0, 0, 0); cyc();
        check("hold_release", int'(edit_value), 5);

        // Both buttons clear once and lock out steps until both released
        do_reset();
        drive(1, 0, 0, 0); cyc();
        for (int i = 0; i < 5; i++) press(1, 1);
        check("clr_pre", int'(edit_value), 300);
        for (int i = 0; i < 21; i++) begin
            drive(1, 1, 1, 0);
            cyc();
            check("clr_both", int'(edit_value), 0);
        end
        for (int i = 0; i < 12; i++) begin
            drive(1, 1, 0, 0);
            cyc();
        end
        check("clr_lock_one", int'(edit_value), 0);
        drive(1, 0, 0, 0); cyc();
        press(0, 1);
        check("clr_unlock", int'(edit_value), 1);
        drive(1, 1, 0, 0); cyc();
        check("clr_seq_pre", int'(edit_value), 61);
        drive(1, 1, 1, 0); cyc();
        check("clr_seq", int'(edit_value), 0);
        drive(1, 0, 0, 0); cyc();

        // Commit held for 7 cycles without ready, then accepted; ready in IDLE ignored
        do_reset();
        drive(1, 0, 0, 0); cyc();
        press(1, 3); press(1, 3);
        for (int i = 0; i < 5; i++) press(0, 1);
        check("wait_pre", int'(edit_value), 125);
        for (int i = 0; i < 7; i++) begin
            drive(0, 0, 0, 0);
            cyc();
            check("wait_valid", int'(load_valid), 1);
            check("wait_load", int'(load_value), 125);
        end
        drive(0, 0, 0, 1); cyc();
        check("wait_done", int'(load_valid), 0);
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 0, 1);
            cyc();
            check("idle_ready", int'(load_valid), 0);
        end
        drive(1, 0, 0, 0); cyc();
        drive(0, 0, 0, 0); cyc(); cyc();
        drive(1, 0, 0, 0); cyc();
        check("abort_valid", int'(load_valid), 0);
        check("abort_editing", int'(editing), 1);
        check("abort_edit", int'(edit_value), 125);

        // Asynchronous reset during COMMIT
        drive(1, 1, 0, 0); cyc();
        drive(0, 0, 0, 0); cyc(); cyc();
        check("arst_pre_valid", int'(load_valid), 1);
        check("arst_pre_load", int'(load_value), 185);
        #3;
        rst = 1'b1;
        #1;
        model_reset();
        check("arst_valid", int'(load_valid), 0);
        check("arst_load", int'(load_value), 0);
        check("arst_edit", int'(edit_value), 0);
        check("arst_editing", int'(editing), 0);
        drive(0, 0, 0, 1);
        cyc();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            check("arst_noload", int'(load_valid), 0);
        end

        // Randomized run against the reference model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) cfg_en = ~cfg_en;
            if ($urandom_range(0, 5) == 0) mins = ~mins;
            if ($urandom_range(0, 6) == 0) secs = ~secs;
            load_ready = ($urandom_range(0, 3) == 0);
            cyc();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_time_entry_ctrl
